// File: rtl/uart_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_decoder_if
// Purpose  : UART line, song-finish input and player control outputs.
// Revision : 1.0
// ============================================================================
interface uart_cmd_decoder_if;
  logic        rx;
  logic        i_finish_song;
  logic [15:0] o_vol;
  logic [3:0]  vol_level;
  logic [2:0]  o_song_select;
  logic        o_pause;
  logic        o_next;
  logic        o_pre;
  logic        o_vol_plus;
  logic        o_vol_dec;
  logic        o_frame_err;

  modport master (
    input  rx, i_finish_song,
    output o_vol, vol_level, o_song_select, o_pause,
           o_next, o_pre, o_vol_plus, o_vol_dec, o_frame_err
  );

  modport slave (
    output rx, i_finish_song,
    input  o_vol, vol_level, o_song_select, o_pause,
           o_next, o_pre, o_vol_plus, o_vol_dec, o_frame_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_decoder
// Purpose  : 8N1 UART receiver and single-byte command decoder for the player.
// Revision : 1.0
// ============================================================================
module uart_cmd_decoder #(
  parameter int         CLK_HZ    = 100_000_000,
  parameter int         BAUD      = 9600,
  parameter int         NUM_SONGS = 4,
  parameter logic [7:0] VOL_STEP  = 8'h1F,
  parameter int         RST_LEVEL = 2
) (
  input wire logic           clk,
  input wire logic           rst_n,
  uart_cmd_decoder_if.master ctrl
);

  localparam int c_div   = CLK_HZ / BAUD;
  localparam int c_half  = c_div / 2;
  localparam int c_cnt_w = $clog2(c_div + 1);

  localparam logic [c_cnt_w-1:0] c_full_last = c_cnt_w'(c_div - 1);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(c_half - 1);
  localparam logic [2:0]         c_last_song = 3'(NUM_SONGS - 1);
  localparam logic [3:0]         c_max_level = 4'd8;
  localparam logic [3:0]         c_rst_level = 4'(RST_LEVEL);
  localparam logic [7:0]         c_rst_att   = 8'(RST_LEVEL) * VOL_STEP;

  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_start     = 3'd1;
  localparam logic [2:0] c_st_data      = 3'd2;
  localparam logic [2:0] c_st_stop      = 3'd3;
  localparam logic [2:0] c_st_wait_high = 3'd4;

  logic               r_rx_meta;
  logic               r_rx_sync;
  logic               r_rx_prev;
  logic [2:0]         r_state;
  logic [c_cnt_w-1:0] r_baud_cnt;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic               r_byte_valid;
  logic               r_frame_err;

  logic               r_fin_prev;
  logic [3:0]         r_vol_level;
  logic [15:0]        r_vol;
  logic [2:0]         r_song;
  logic               r_pause;
  logic               r_next;
  logic               r_pre;
  logic               r_vol_plus;
  logic               r_vol_dec;

  logic               w_rx_fall;
  logic               w_cmd_pause;
  logic               w_cmd_next;
  logic               w_cmd_prev;
  logic               w_cmd_louder;
  logic               w_cmd_quieter;
  logic               w_fin_rise;
  logic [2:0]         w_song_inc;
  logic [2:0]         w_song_dec;
  logic [7:0]         w_att;

  assign w_rx_fall = r_rx_prev & ~r_rx_sync;

  // Synchronizer flops reset low so a line held low through reset release
  // never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_meta    <= 1'b0;
      r_rx_sync    <= 1'b0;
      r_rx_prev    <= 1'b0;
      r_state      <= c_st_idle;
      r_baud_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_meta    <= ctrl.rx;
      r_rx_sync    <= r_rx_meta;
      r_rx_prev    <= r_rx_sync;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_rx_fall) begin
            r_state    <= c_st_start;
            r_baud_cnt <= '0;
          end
        end
        c_st_start: begin
          if (r_baud_cnt == c_half_last) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_state    <= r_rx_sync ? c_st_idle : c_st_data;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        c_st_data: begin
          if (r_baud_cnt == c_full_last) begin
            r_baud_cnt <= '0;
            r_shift    <= {r_rx_sync, r_shift[7:1]};
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= c_st_stop;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        c_st_stop: begin
          if (r_baud_cnt == c_full_last) begin
            r_baud_cnt <= '0;
            if (r_rx_sync) begin
              r_byte_valid <= 1'b1;
              r_state      <= c_st_idle;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= c_st_wait_high;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        c_st_wait_high: begin
          if (r_rx_sync) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign w_cmd_pause   = r_byte_valid && (r_shift == 8'h01);
  assign w_cmd_next    = r_byte_valid && (r_shift == 8'h02);
  assign w_cmd_prev    = r_byte_valid && (r_shift == 8'h03);
  assign w_cmd_louder  = r_byte_valid && (r_shift == 8'h04);
  assign w_cmd_quieter = r_byte_valid && (r_shift == 8'h05);
  assign w_fin_rise    = ctrl.i_finish_song & ~r_fin_prev;
  assign w_song_inc    = (r_song == c_last_song) ? 3'd0 : r_song + 3'd1;
  assign w_song_dec    = (r_song == 3'd0) ? c_last_song : r_song - 3'd1;
  assign w_att         = {4'd0, r_vol_level} * VOL_STEP;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fin_prev  <= 1'b0;
      r_vol_level <= c_rst_level;
      r_vol       <= {c_rst_att, c_rst_att};
      r_song      <= 3'd0;
      r_pause     <= 1'b0;
      r_next      <= 1'b0;
      r_pre       <= 1'b0;
      r_vol_plus  <= 1'b0;
      r_vol_dec   <= 1'b0;
    end else begin
      r_fin_prev <= ctrl.i_finish_song;
      r_vol      <= {w_att, w_att};
      r_next     <= 1'b0;
      r_pre      <= 1'b0;
      r_vol_plus <= 1'b0;
      r_vol_dec  <= 1'b0;

      // A previous command swallows a coincident finish edge; a next command
      // merges with it so the song moves by one only.
      if (w_cmd_prev) begin
        r_song <= w_song_dec;
        r_pre  <= 1'b1;
      end else if (w_cmd_next || w_fin_rise) begin
        r_song <= w_song_inc;
        r_next <= w_cmd_next;
      end

      if (w_cmd_pause) begin
        r_pause <= ~r_pause;
      end else if (w_cmd_next || w_cmd_prev) begin
        r_pause <= 1'b0;
      end

      if (w_cmd_louder && (r_vol_level != 4'd0)) begin
        r_vol_level <= r_vol_level - 4'd1;
        r_vol_plus  <= 1'b1;
      end else if (w_cmd_quieter && (r_vol_level < c_max_level)) begin
        r_vol_level <= r_vol_level + 4'd1;
        r_vol_dec   <= 1'b1;
      end
    end
  end

  assign ctrl.o_vol         = r_vol;
  assign ctrl.vol_level     = r_vol_level;
  assign ctrl.o_song_select = r_song;
  assign ctrl.o_pause       = r_pause;
  assign ctrl.o_next        = r_next;
  assign ctrl.o_pre         = r_pre;
  assign ctrl.o_vol_plus    = r_vol_plus;
  assign ctrl.o_vol_dec     = r_vol_dec;
  assign ctrl.o_frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Bluetooth-UART command front end of the MP3 player. Receives 8N1 bytes from the HC-style Bluetooth module on `rx`, decodes single-byte commands, and keeps the player control state: volume level and VS1003 SCI_VOL word, song index, and pause flag. It also emits one-cycle event strobes. It sits directly upstream of the `mp3` driver, VGA, counter and volume-LED blocks, and takes `i_finish_song` back from `mp3` for auto-advance.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `BAUD`, 9600, UART bit rate; bit period `DIV = CLK_HZ/BAUD` cycles (integer division).
- `NUM_SONGS`, 4, number of songs; legal range 2..8.
- `VOL_STEP`, 8'h1F, SCI_VOL attenuation added per volume level.
- `RST_LEVEL`, 2, volume level loaded at reset.

- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `rx` in 1: asynchronous UART line, idle high.
- `i_finish_song` in 1: end of song from `mp3`; the block acts on its rising edge.
- `o_vol` out 16: SCI_VOL word `{att, att}`, with `att = vol_level*VOL_STEP`.
- `vol_level` out 4: 0 (loudest) to 8 (quietest).
- `o_song_select` out 3: current song index, 0 to NUM_SONGS-1.
- `o_pause` out 1: 1 means playback paused.
- `o_next`, `o_pre` out 1: one-cycle strobes on a song change by command.
- `o_vol_plus`, `o_vol_dec` out 1: one-cycle strobes when `vol_level` actually changes.
- `o_frame_err` out 1: one-cycle strobe when a received byte has a bad stop bit.

## Operation
- `rx` passes through a 2-flop synchronizer. A third flop keeps the previous synchronized value for falling-edge detection.
- RX FSM states and transitions:
  - IDLE: a falling edge on synced `rx` moves to START and clears the baud counter.
  - START: wait DIV/2 cycles, then sample. If the line is low, go to DATA. If high, treat it as a glitch and return to IDLE.
  - DATA: sample every DIV cycles, 8 bits, LSB first, into a shift register.
  - STOP: sample after DIV cycles. If high, pulse internal `byte_valid` and go to IDLE. If low, pulse `o_frame_err`, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: wait until synced `rx` is 1, then go to IDLE.
- Command decode runs on `byte_valid`:
  - 8'h01: toggle `o_pause`.
  - 8'h02: next song. `song = (song==NUM_SONGS-1) ? 0 : song+1`; pulse `o_next`; clear `o_pause`.
  - 8'h03: previous song. `song = (song==0) ? NUM_SONGS-1 : song-1`; pulse `o_pre`; clear `o_pause`.
  - 8'h04: louder. If `vol_level > 0`, decrement it and pulse `o_vol_plus`. At 0, do nothing and raise no strobe.
  - 8'h05: quieter. If `vol_level < 8`, increment it and pulse `o_vol_dec`. At 8, do nothing.
  - Any other byte is ignored with no output change.
- Auto-advance: a rising edge on `i_finish_song` advances the song exactly as 8'h02 does, but with no `o_next` strobe. It does not change `o_pause`.
- Simultaneous events in the same cycle:
  - Finish edge with a next command: advance by 1 only and pulse `o_next`.
  - Finish edge with a previous command: the previous command wins, and the finish edge is dropped.
- `o_vol` is registered from `vol_level`. Compute `att` in 8 bits; the product cannot overflow because 8*8'h1F = 8'hF8.
- Reset values: `vol_level=RST_LEVEL`, `o_vol={RST_LEVEL*VOL_STEP, RST_LEVEL*VOL_STEP}` (16'h3E3E at defaults), `o_song_select=0`, `o_pause=0`, all strobes 0, RX FSM in IDLE.
- Reset mid-frame aborts the frame with no partial decode. If `rx` is low when reset releases, it is not taken as a start bit; a fresh falling edge is required.

## Timing
- Synchronizer latency is 2 cycles from a pin change to synced `rx`.
- The start bit is sampled DIV/2 cycles after the detected falling edge. Data bit k is sampled `DIV/2 + (k+1)*DIV` cycles after it, k = 0..7. The stop bit is sampled at `DIV/2 + 9*DIV`.
- `byte_valid` is high in the cycle after the stop-bit sample edge.
- Control registers and strobes update on the next edge, i.e. 2 cycles after the stop sample.
- `o_vol` follows `vol_level` 1 cycle later.
- Strobes are exactly 1 cycle wide.
- Back-to-back bytes with zero idle time are accepted. IDLE is re-entered 1 cycle after the stop sample, well inside the stop bit.
- The receiver tolerates a baud mismatch of ±2%.

## Test plan
- Reset: after reset, `vol_level=2`, `o_vol=16'h3E3E`, `o_song_select=0`, `o_pause=0`, and no strobe.
- Send 8'h02 four times with NUM_SONGS=4: song goes 1, 2, 3, 0, with `o_next` high 1 cycle each time, exactly 2 cycles after each stop sample. Then send 8'h03: song becomes 3 and `o_pre` pulses.
- Send 8'h04 three times from level 2: levels go 1, 0, 0, with `o_vol_plus` pulsing only twice and `o_vol=16'h0000`. Then send 8'h05 nine times: level saturates at 8, `o_vol=16'hF8F8`, and `o_vol_dec` pulses 8 times.
- Pause: send 8'h01 (`o_pause=1`), then 8'h02; the song advances and `o_pause` returns to 0. Hold `i_finish_song` high for 50 cycles: the song advances once only, with no `o_next`.
- Robustness: a 1000-cycle low glitch on `rx` produces no byte. A byte with stop bit=0 pulses `o_frame_err` and leaves state unchanged. Bytes 8'h41 and 8'hFF are ignored.
- Corner cases: a finish edge in the same cycle as the 8'h02 decode advances by 1 only. Asserting `rst_n=0` during data bit 4 of 8'h02 leaves `o_song_select=0` after release, and the next full byte decodes correctly.
